regfile_writeback: RTL and testbench

Writeback controller that drives the register file's single write port (clock, ctrl_writeEnable, ctrl_writeReg, data_writeReg).
- Merges the in-order pipeline writeback stream with out-of-order results from the multi-cycle mult/div unit, using a small result queue.
- Keeps a busy scoreboard so decode can stall on pending mult/div destinations.
- Supplies forwarded read data, because the register file floats its read ports on a same-cycle write/read collision.

---
 rtl/regfile_writeback.sv | 166 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback controller: merges pipeline writes with queued mult/div results,
// tracks pending mult/div destinations, and resolves read data. Optional macro: WB_FORWARD_EN.
module regfile_writeback #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5
) (
  input  logic                       clock,
  input  logic                       ctrl_reset_n,
  input  logic                       pipe_we,
  input  logic [ADDR_W-1:0]          pipe_rd,
  input  logic [DATA_W-1:0]          pipe_data,
  output logic                       pipe_stall,
  input  logic                       md_issue,
  input  logic [ADDR_W-1:0]          md_issue_rd,
  input  logic                       md_valid,
  input  logic [ADDR_W-1:0]          md_rd,
  input  logic [DATA_W-1:0]          md_data,
  output logic                       md_ready,
  output logic                       ctrl_writeEnable,
  output logic [ADDR_W-1:0]          ctrl_writeReg,
  output logic [DATA_W-1:0]          data_writeReg,
  input  logic [ADDR_W-1:0]          ctrl_readRegA,
  input  logic [ADDR_W-1:0]          ctrl_readRegB,
  input  logic [DATA_W-1:0]          raw_readRegA,
  input  logic [DATA_W-1:0]          raw_readRegB,
  output logic [DATA_W-1:0]          data_readRegA,
  output logic [DATA_W-1:0]          data_readRegB,
  output logic                       busyA,
  output logic                       busyB,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       err_drop
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG     = 1 << ADDR_W;

  logic [ADDR_W-1:0] qRd   [DEPTH];
  logic [DATA_W-1:0] qData [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [STARVE_W-1:0] starveCnt;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busyNext;

  logic notEmpty;
  logic push;
  logic popStall;
  logic pipeWrite;
  logic popIdle;
  logic pop;
  logic pipeLive;
  logic [ADDR_W-1:0] headRd;
  logic [DATA_W-1:0] headData;

  assign notEmpty   = (queue_count != '0);
  assign md_ready   = (queue_count < CNT_W'(DEPTH));
  assign push       = md_valid && md_ready;
  assign pipe_stall = (starveCnt == STARVE_W'(STARVE_LIMIT)) && notEmpty;
  assign pipeLive   = pipe_we && (pipe_rd != '0);
  assign headRd     = qRd[rdPtr];
  assign headData   = qData[rdPtr];

  // Priority: a starved queue head beats the pipeline, otherwise the pipeline wins.
  assign popStall  = pipe_stall;
  assign pipeWrite = !popStall && pipeLive;
  assign popIdle   = !popStall && !pipeLive && notEmpty;
  assign pop       = popStall || popIdle;

  always_ff @(posedge clock) begin
    if (push) begin
      qRd[wrPtr]   <= md_rd;
      qData[wrPtr] <= md_data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      queue_count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   queue_count <= queue_count + CNT_W'(1);
        2'b01:   queue_count <= queue_count - CNT_W'(1);
        default: queue_count <= queue_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      starveCnt <= '0;
    end else if (!notEmpty || pop) begin
      starveCnt <= '0;
    end else if (starveCnt != STARVE_W'(STARVE_LIMIT)) begin
      starveCnt <= starveCnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      err_drop         <= 1'b0;
    end else begin
      if (pop) begin
        // Head entries aimed at r0 are retired without a write strobe.
        ctrl_writeEnable <= (headRd != '0);
        ctrl_writeReg    <= headRd;
        data_writeReg    <= headData;
      end else if (pipeWrite) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= pipe_rd;
        data_writeReg    <= pipe_data;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
      if (popStall && pipeLive) err_drop <= 1'b1;
    end
  end

  always_comb begin
    busyNext = busy;
    if (pop) busyNext[headRd] = 1'b0;
    if (md_issue) busyNext[md_issue_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) busy <= '0;
    else               busy <= busyNext;
  end

  assign busyA = busy[ctrl_readRegA];
  assign busyB = busy[ctrl_readRegB];

`ifdef WB_FORWARD_EN
  // The register file floats its read port on a same-cycle write/read collision.
  always_comb begin
    data_readRegA = raw_readRegA;
    if (ctrl_readRegA == '0)
      data_readRegA = '0;
    else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA))
      data_readRegA = data_writeReg;
  end

  always_comb begin
    data_readRegB = raw_readRegB;
    if (ctrl_readRegB == '0)
      data_readRegB = '0;
    else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB))
      data_readRegB = data_writeReg;
  end
`else
  assign data_readRegA = raw_readRegA;
  assign data_readRegB = raw_readRegB;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized scoreboard bench for regfile_writeback against a queue-based reference model.
`timescale 1ns/1ps
module tb_regfile_writeback;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;

  logic clock;
  logic ctrl_reset_n;
  logic pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic pipe_stall;
  logic md_issue;
  logic [ADDR_W-1:0] md_issue_rd;
  logic md_valid;
  logic [ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0] md_data;
  logic md_ready;
  logic ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] raw_readRegA;
  logic [DATA_W-1:0] raw_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;
  logic busyA;
  logic busyB;
  logic [$clog2(DEPTH):0] queue_count;
  logic err_drop;

  regfile_writeback #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .raw_readRegA(raw_readRegA), .raw_readRegB(raw_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .busyA(busyA), .busyB(busyB), .queue_count(queue_count), .err_drop(err_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct { logic [4:0] rd; logic [31:0] data; int tag; } wr_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  wr_t  expWr[$];
  ent_t mq[$];
  int   starve;
  logic errM;
  logic [31:0] busyM;
  logic lastWe;
  logic [4:0] lastRd;
  logic [31:0] lastData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] idx, input logic [31:0] raw);
`ifdef WB_FORWARD_EN
    if (idx == 5'd0) return 32'd0;
    if (lastWe && lastRd == idx) return lastData;
    return raw;
`else
    return raw;
`endif
  endfunction

  always @(posedge clock) cyc++;

  // Monitor: each write strobe must match the oldest expected write, in the expected cycle.
  always begin
    wr_t e;
    @(posedge clock);
    #1;
    if (ctrl_reset_n) begin
      if (ctrl_writeEnable) begin
        if (expWr.size() == 0) begin
          check("unexpected_write_reg", {27'd0, ctrl_writeReg}, 32'hFFFF_FFFF);
        end else begin
          e = expWr.pop_front();
          check("write_cycle", cyc, e.tag);
          check("write_reg", {27'd0, ctrl_writeReg}, {27'd0, e.rd});
          check("write_data", data_writeReg, e.data);
        end
      end else if (expWr.size() > 0 && expWr[0].tag <= cyc) begin
        e = expWr.pop_front();
        check("write_enable", {31'd0, ctrl_writeEnable}, 32'd1);
      end
    end
  end

  task automatic clearModel();
    mq.delete();
    expWr.delete();
    starve   = 0;
    errM     = 1'b0;
    busyM    = '0;
    lastWe   = 1'b0;
    lastRd   = '0;
    lastData = '0;
  endtask

  task automatic idleInputs();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    md_issue = 0; md_issue_rd = 0; md_valid = 0; md_rd = 0; md_data = 0;
    ctrl_readRegA = 0; ctrl_readRegB = 0; raw_readRegA = 0; raw_readRegB = 0;
  endtask

  task automatic doReset();
    #2;
    idleInputs();
    ctrl_reset_n = 1'b0;
    #1;
    check("rst_writeEnable", {31'd0, ctrl_writeEnable}, 32'd0);
    check("rst_writeReg", {27'd0, ctrl_writeReg}, 32'd0);
    check("rst_writeData", data_writeReg, 32'd0);
    check("rst_err_drop", {31'd0, err_drop}, 32'd0);
    check("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
    check("rst_queue_count", {29'd0, queue_count}, 32'd0);
    check("rst_md_ready", {31'd0, md_ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      #0.1;
      check("rst_busyA", {31'd0, busyA}, 32'd0);
    end
    clearModel();
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                      input logic iss, input logic [4:0] issRd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] rawA, rawB;
    bit nonEmpty, stallM, accept, popped, nw;
    logic [4:0] nrd;
    logic [31:0] ndat;
    ent_t h;
    rawA = $urandom; rawB = $urandom;
    pipe_we = pwe; pipe_rd = prd; pipe_data = pdat;
    md_issue = iss; md_issue_rd = issRd;
    md_valid = mv; md_rd = mrd; md_data = mdat;
    ctrl_readRegA = ra; ctrl_readRegB = rb;
    raw_readRegA = rawA; raw_readRegB = rawB;
    #1;
    nonEmpty = (mq.size() > 0);
    stallM   = (starve == STARVE_LIMIT) && nonEmpty;
    check("queue_count", {29'd0, queue_count}, mq.size());
    check("md_ready", {31'd0, md_ready}, {31'd0, mq.size() < DEPTH});
    check("pipe_stall", {31'd0, pipe_stall}, {31'd0, stallM});
    check("err_drop", {31'd0, err_drop}, {31'd0, errM});
    check("busyA", {31'd0, busyA}, {31'd0, busyM[ra]});
    check("busyB", {31'd0, busyB}, {31'd0, busyM[rb]});
    check("data_readRegA", data_readRegA, expRead(ra, rawA));
    check("data_readRegB", data_readRegB, expRead(rb, rawB));

    accept = mv && (mq.size() < DEPTH);
    popped = 0; nw = 0; nrd = 0; ndat = 0;
    if (stallM) begin
      h = mq.pop_front(); popped = 1;
      if (pwe && prd != 0) errM = 1'b1;
    end else if (pwe && prd != 0) begin
      nw = 1; nrd = prd; ndat = pdat;
    end else if (nonEmpty) begin
      h = mq.pop_front(); popped = 1;
    end
    if (popped && h.rd != 0) begin
      nw = 1; nrd = h.rd; ndat = h.data;
      busyM[h.rd] = 1'b0;
    end
    if (nw) begin
      expWr.push_back('{rd: nrd, data: ndat, tag: cyc + 1});
      lastRd = nrd; lastData = ndat;
    end
    lastWe = nw;
    if (iss && issRd != 0) busyM[issRd] = 1'b1;
    if (accept) mq.push_back('{rd: mrd, data: mdat});
    if (!nonEmpty || popped) starve = 0;
    else if (starve < STARVE_LIMIT) starve++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, ra, 5'($urandom_range(0, 31)));
  endtask

  initial begin
    bit stallNow;
    logic [4:0] ra;
    idleInputs();
    ctrl_reset_n = 1'b0;
    clearModel();
    repeat (2) @(posedge clock);
    #1;
    doReset();

    // pipeline write with same-cycle read of the written index
    step(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5);
    idle(2, 5'd5);

    // mult/div path: busy set on issue, cleared on its write
    step(0, 0, 0, 1, 5'd7, 0, 0, 0, 5'd7, 5'd7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    step(0, 0, 0, 0, 0, 1, 5'd7, 32'h1234, 5'd7, 5'd7);
    idle(4, 5'd7);

    // fill the queue under a continuous pipeline stream, then starve it
    for (int i = 0; i < 5; i++)
      step(1, 5'(i + 1), $urandom, 1, 5'(10 + i), 1, 5'(10 + i), $urandom, 5'(10 + i), 5'(i + 1));
    for (int i = 0; i < 12; i++)
      step(1, 5'(20 + (i % 8)), $urandom, 0, 0, 0, 0, 0, 5'(20 + (i % 8)), 5'd10);
    check("err_drop_after_starve", {31'd0, err_drop}, 32'd1);
    idle(8, 5'd11);

    // reset with three results queued
    for (int i = 0; i < 3; i++)
      step(1, 5'd3, $urandom, 1, 5'(i + 1), 1, 5'(i + 1), $urandom, 5'd1, 5'd2);
    doReset();

    // register 0 never written
    step(1, 5'd0, 32'hAAAA_5555, 0, 0, 1, 5'd0, 32'h5555_AAAA, 5'd0, 5'd0);
    idle(3, 5'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) doReset();
      stallNow = (starve == STARVE_LIMIT) && (mq.size() > 0);
      ra = ($urandom_range(0, 3) == 0 && lastWe) ? lastRd : 5'($urandom_range(0, 31));
      step(stallNow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
           ra, 5'($urandom_range(0, 31)));
    end
    idle(12, 5'd0);
    check("pending_writes", expWr.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
